// File: rtl/cdc_arb_pkg.sv
// Shared types and defaults for the clock-domain-crossing request arbiter.
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } cdcarbstate_t;

    localparam int DEF_N       = 4;
    localparam int DEF_TIMEOUT = 256;
    localparam int DEF_CW      = 9;

endpackage

// File: rtl/cdc_sync2.sv
// Two-stage level synchronizer; no reset so a held request survives a reset pulse.
module cdc_sync2 (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous level and let the first stage settle for one cycle.
    always_ff @(posedge clk) begin
        meta_q <= d;
        sync_q <= meta_q;
    end

    assign q = sync_q;

endmodule

// File: rtl/rr_pick.sv
// Wrap-around priority search: first set request at or after ptr.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        valid = |req;
        idx   = {IW{1'b0}};
        cand  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            idx  = req[cand] ? IW'(cand) : idx;
        end
    end

endmodule

// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter granting one clk-domain resource to N asynchronous
// 4-phase requesters, with a watchdog that forces an abort from GRANT.
module cdc_req_arbiter
    import cdc_arb_pkg::*;
#(
    parameter  int N       = DEF_N,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    parameter  int CW      = DEF_CW,
    localparam int IW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [N-1:0]  AsyncReq,
    output logic [N-1:0]  Ack,
    output logic [N-1:0]  Grant,
    output logic [IW-1:0] GrantIdx,
    input  logic          Done,
    output logic          Busy,
    output logic          TimeoutErr
);

    localparam bit            WD_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        logic [N-1:0] v;
        v    = {N{1'b0}};
        v[i] = 1'b1;
        return v;
    endfunction

    logic [N-1:0]  sreq_s;
    logic          pick_valid_s;
    logic [IW-1:0] pick_idx_s;

    cdcarbstate_t  state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          terr_q, terr_d;

    for (genvar g = 0; g < N; g++) begin : g_sync
        cdc_sync2 u_sync (
            .clk (clk),
            .d   (AsyncReq[g]),
            .q   (sreq_s[g])
        );
    end

    rr_pick #(.N(N)) u_pick (
        .req   (sreq_s),
        .ptr   (ptr_q),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Next-state and next-output computation for the IDLE/GRANT/ACK handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = ack_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d = GRANT;
                    grant_d = onehot(pick_idx_s);
                    idx_d   = pick_idx_s;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    grant_d = {N{1'b0}};
                end
            end
            GRANT: begin
                // Done outranks a simultaneous watchdog expiry.
                if (Done) begin
                    state_d = ACK;
                    grant_d = {N{1'b0}};
                    ack_d   = onehot(idx_q);
                end else if (WD_EN && (cnt_q == TO_LAST)) begin
                    state_d = ACK;
                    grant_d = {N{1'b0}};
                    ack_d   = onehot(idx_q);
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACK: begin
                if (!sreq_s[idx_q]) begin
                    state_d = IDLE;
                    ack_d   = {N{1'b0}};
                    ptr_d   = (idx_q == IW'(N - 1)) ? {IW{1'b0}} : idx_q + IW'(1);
                end else begin
                    ack_d = onehot(idx_q);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {N{1'b0}};
                ack_d   = {N{1'b0}};
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and all outputs registered together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= {N{1'b0}};
            ack_q   <= {N{1'b0}};
            idx_q   <= {IW{1'b0}};
            ptr_q   <= {IW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

    assign Grant      = grant_q;
    assign Ack        = ack_q;
    assign GrantIdx   = idx_q;
    assign Busy       = busy_q;
    assign TimeoutErr = terr_q;

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Directed bench for cdc_req_arbiter: grant order is scoreboarded, handshake
// timing and watchdog behaviour are checked inline.
module tb_cdc_req_arbiter;

    logic       clk;
    logic       resetn;
    logic [3:0] AsyncReq;
    logic [3:0] Ack;
    logic [3:0] Grant;
    logic [1:0] GrantIdx;
    logic       Done;
    logic       Busy;
    logic       TimeoutErr;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    logic [3:0] prev_grant = 4'b0000;

    cdc_req_arbiter #(.N(4), .TIMEOUT(8), .CW(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .AsyncReq   (AsyncReq),
        .Ack        (Ack),
        .Grant      (Grant),
        .GrantIdx   (GrantIdx),
        .Done       (Done),
        .Busy       (Busy),
        .TimeoutErr (TimeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rising Grant must match the next queued requester.
    always @(negedge clk) begin
        if (Grant !== 4'b0000 && prev_grant === 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", 32'(Grant), 32'd0);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("grant_order", 32'(Grant), 32'(1) << e);
                check("grant_idx", 32'(GrantIdx), 32'(e));
            end
        end
        prev_grant = Grant;
    end

    task automatic run_txn(input int w, input int dly, input logic [3:0] drop, input bit reraise);
        for (int i = 0; i < 8 && Grant === 4'b0000; i++) step();
        check("txn_grant", 32'(Grant), 32'(1) << w);
        check("txn_busy", 32'(Busy), 32'd1);
        repeat (dly) step();
        Done = 1'b1;
        step();
        Done = 1'b0;
        check("txn_ack", 32'(Ack), 32'(1) << w);
        check("txn_grant_drop", 32'(Grant), 32'd0);
        check("txn_no_terr", 32'(TimeoutErr), 32'd0);
        AsyncReq = AsyncReq & ~drop;
        step();
        step();
        check("txn_ack_hold", 32'(Ack), 32'(1) << w);
        step();
        check("txn_ack_fall", 32'(Ack), 32'd0);
        if (reraise) AsyncReq[w] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cycles;
        resetn   = 1'b0;
        AsyncReq = 4'b0000;
        Done     = 1'b0;
        repeat (4) step();
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_ack", 32'(Ack), 32'd0);
        check("rst_idx", 32'(GrantIdx), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_terr", 32'(TimeoutErr), 32'd0);
        resetn = 1'b1;
        step();

        // Single request from requester 1 with Done five cycles into the grant.
        exp_q.push_back(1);
        AsyncReq = 4'b0010;
        step();
        step();
        check("s1_no_grant_yet", 32'(Grant), 32'd0);
        step();
        check("s1_grant", 32'(Grant), 32'h2);
        check("s1_idx", 32'(GrantIdx), 32'd1);
        check("s1_busy", 32'(Busy), 32'd1);
        repeat (4) step();
        Done = 1'b1;
        step();
        Done = 1'b0;
        check("s1_ack", 32'(Ack), 32'h2);
        check("s1_grant_off", 32'(Grant), 32'd0);
        AsyncReq = 4'b0000;
        step();
        step();
        check("s1_ack_hold", 32'(Ack), 32'h2);
        step();
        check("s1_ack_fall", 32'(Ack), 32'd0);
        check("s1_idle", 32'(Busy), 32'd0);

        // Pointer now at 2: with requesters 0, 2 and 3 asking, 2 wins.
        exp_q.push_back(2);
        AsyncReq = 4'b1101;
        run_txn(2, 1, 4'b1111, 1'b0);

        // All four requesting from reset release: strict rotation 0,1,2,3,0.
        resetn   = 1'b0;
        AsyncReq = 4'b1111;
        step();
        step();
        step();
        foreach (exp_q[i]) check("s2_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) run_txn(k, 1, 4'(1 << k), 1'b1);
        run_txn(0, 1, 4'b1111, 1'b0);

        // Watchdog: requester 0, Done never comes.
        exp_q.push_back(0);
        AsyncReq = 4'b0001;
        step();
        step();
        step();
        check("s3_grant", 32'(Grant), 32'h1);
        cycles = 0;
        for (int i = 0; i < 20 && Grant !== 4'b0000; i++) begin
            cycles++;
            step();
        end
        check("s3_grant_cycles", 32'(cycles), 32'd8);
        check("s3_ack", 32'(Ack), 32'h1);
        check("s3_terr", 32'(TimeoutErr), 32'd1);
        step();
        check("s3_terr_pulse", 32'(TimeoutErr), 32'd0);
        check("s3_ack_hold", 32'(Ack), 32'h1);
        AsyncReq = 4'b0000;
        repeat (3) step();
        check("s3_ack_fall", 32'(Ack), 32'd0);

        // Done on the last watchdog cycle: Done wins, no error pulse.
        exp_q.push_back(0);
        AsyncReq = 4'b0001;
        repeat (3) step();
        check("s4_grant", 32'(Grant), 32'h1);
        repeat (7) step();
        check("s4_grant_held", 32'(Grant), 32'h1);
        Done = 1'b1;
        step();
        Done = 1'b0;
        check("s4_ack", 32'(Ack), 32'h1);
        check("s4_no_terr", 32'(TimeoutErr), 32'd0);
        step();
        check("s4_no_terr_late", 32'(TimeoutErr), 32'd0);
        AsyncReq = 4'b0000;
        repeat (3) step();
        check("s4_ack_fall", 32'(Ack), 32'd0);

        // Wrap-around: after serving 2 the pointer is 3, so 0 beats 1.
        exp_q.push_back(2);
        AsyncReq = 4'b0100;
        run_txn(2, 1, 4'b0100, 1'b0);
        exp_q.push_back(0);
        exp_q.push_back(1);
        AsyncReq = 4'b0011;
        run_txn(0, 1, 4'b0001, 1'b0);
        run_txn(1, 1, 4'b0010, 1'b0);

        // Reset in the middle of a grant to requester 2.
        exp_q.push_back(2);
        AsyncReq = 4'b0100;
        repeat (3) step();
        check("s6_grant", 32'(Grant), 32'h4);
        step();
        resetn = 1'b0;
        #1;
        check("s6_rst_grant", 32'(Grant), 32'd0);
        check("s6_rst_ack", 32'(Ack), 32'd0);
        check("s6_rst_busy", 32'(Busy), 32'd0);
        step();
        step();
        exp_q.push_back(2);
        resetn = 1'b1;
        for (int i = 0; i < 3 && Grant === 4'b0000; i++) step();
        check("s6_regrant", 32'(Grant), 32'h4);
        run_txn(2, 1, 4'b0100, 1'b0);

        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
